// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard sequencer: register-address width and FSM states.
// Also used by the pipeline top to decode seq_state.
package hazard_pkg;

    localparam int REG_W = 3;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: flags an ID instruction that reads the register an EX load writes.
// Zero latency, no state.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_memread,
    output logic             load_use
);

    assign load_use = ex_memread && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Stall/flush controller: mem_busy > branch_taken > load_use; Mealy outputs act in the hazard cycle.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall_cycles/flush_count outputs.
module pipeline_hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 2,
    parameter int MEM_TIMEOUT       = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_memread,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_write,
    output logic             exmem_write,
    output logic [1:0]       seq_state,
    output logic             mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      flush_count
`endif
);

    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_W  = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    state_t     ret_q, ret_d;
    state_t     resume;
    logic [2:0] stall_cnt_q, stall_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;
    logic       load_use;

    logic pc_w, ifid_w, flush, bubble, idex_w, exmem_w;

    load_use_detect u_load_use_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_rt      (ex_rt),
        .ex_memread (ex_memread),
        .load_use   (load_use)
    );

    always_comb begin
        pc_w        = 1'b1;
        ifid_w      = 1'b1;
        flush       = 1'b0;
        bubble      = 1'b0;
        idex_w      = 1'b1;
        exmem_w     = 1'b1;
        state_d     = state_q;
        ret_d       = ret_q;
        stall_cnt_d = stall_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        // While waiting on memory, behave as the state we were interrupted in.
        resume      = (state_q == MEM_WAIT) ? ret_q : state_q;

        if (mem_busy) begin
            pc_w       = 1'b0;
            ifid_w     = 1'b0;
            idex_w     = 1'b0;
            exmem_w    = 1'b0;
            state_d    = MEM_WAIT;
            ret_d      = resume;
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
            if (wait_cnt_d >= TIMEOUT_W) begin
                err_d = 1'b1;
            end
        end else begin
            wait_cnt_d = 8'd0;
            case (resume)
                LOAD_STALL: begin
                    pc_w        = 1'b0;
                    ifid_w      = 1'b0;
                    bubble      = 1'b1;
                    stall_cnt_d = stall_cnt_q - 3'd1;
                    state_d     = (stall_cnt_q == 3'd1) ? RUN : LOAD_STALL;
                end
                default: begin
                    state_d = RUN;
                    if (branch_taken) begin
                        flush  = 1'b1;
                        bubble = 1'b1;
                    end else if (load_use) begin
                        pc_w   = 1'b0;
                        ifid_w = 1'b0;
                        bubble = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d     = LOAD_STALL;
                            stall_cnt_d = STALL_INIT;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            ret_q       <= RUN;
            stall_cnt_q <= 3'd0;
            wait_cnt_q  <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            stall_cnt_q <= stall_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
        end
    end

    // Held at the defaults while reset is asserted, regardless of hazard inputs.
    assign pc_write        = rst | pc_w;
    assign ifid_write      = rst | ifid_w;
    assign ifid_flush      = ~rst & flush;
    assign idex_bubble     = ~rst & bubble;
    assign idex_write      = rst | idex_w;
    assign exmem_write     = rst | exmem_w;
    assign seq_state       = state_q;
    assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles_q, flush_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 16'd0;
            flush_count_q  <= 16'd0;
        end else begin
            if (!pc_write && stall_cycles_q != 16'hFFFF) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
            if (ifid_flush && flush_count_q != 16'hFFFF) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer (LOAD_STALL_CYCLES=2, MEM_TIMEOUT=15).
// Inputs change on the falling edge; Mealy outputs are checked 1 time unit later.
module tb_pipeline_hazard_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_memread, branch_taken, mem_busy;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, exmem_write;
    logic [1:0] seq_state;
    logic       mem_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cycles, flush_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int pc_low   = 0;

    // Packed output vector: {pc, ifid_w, flush, bubble, idex_w, exmem_w}
    localparam logic [5:0] O_DEF    = 6'b110011;
    localparam logic [5:0] O_STALL  = 6'b000111;
    localparam logic [5:0] O_BRANCH = 6'b111111;
    localparam logic [5:0] O_BUSY   = 6'b000000;

    always #5 clk = ~clk;

    pipeline_hazard_sequencer #(
        .LOAD_STALL_CYCLES (2),
        .MEM_TIMEOUT       (15)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .ex_rt           (ex_rt),
        .ex_memread      (ex_memread),
        .branch_taken    (branch_taken),
        .mem_busy        (mem_busy),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .idex_write      (idex_write),
        .exmem_write     (exmem_write),
        .seq_state       (seq_state),
        .mem_timeout_err (mem_timeout_err)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [5:0] exp, input logic [1:0] st);
        check({tag, "_outs"}, 32'({pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, exmem_write}), 32'(exp));
        check({tag, "_state"}, 32'(seq_state), 32'(st));
        if (pc_write === 1'b0) pc_low++;
    endtask

    initial begin
        rst = 1'b1; id_rs = 3'd0; id_rt = 3'd0; ex_rt = 3'd7;
        id_uses_rt = 1'b0; ex_memread = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
        #2;
        check_outs("reset", O_DEF, 2'd0);
        check("reset_err", 32'(mem_timeout_err), 32'd0);

        // Load r3 then add r4,r3,r1: two bubbles, states 0,1,0
        @(negedge clk);
        rst = 1'b0;
        ex_memread = 1'b1; ex_rt = 3'd3; id_rs = 3'd3; id_rt = 3'd1; id_uses_rt = 1'b1;
        #1 check_outs("lu_c0", O_STALL, 2'd0);
        @(negedge clk);
        ex_memread = 1'b0;
        #1 check_outs("lu_c1", O_STALL, 2'd1);
        @(negedge clk);
        #1 check_outs("lu_done", O_DEF, 2'd0);

        // Branch wins over a simultaneous load-use
        @(negedge clk);
        branch_taken = 1'b1; ex_memread = 1'b1; ex_rt = 3'd3; id_rs = 3'd3;
        #1 check_outs("br_lu", O_BRANCH, 2'd0);
        @(negedge clk);
        branch_taken = 1'b0; ex_memread = 1'b0;
        #1 check_outs("br_next", O_DEF, 2'd0);

        // rt match ignored when the instruction does not read rt
        @(negedge clk);
        ex_memread = 1'b1; ex_rt = 3'd2; id_rt = 3'd2; id_rs = 3'd5; id_uses_rt = 1'b0;
        #1 check_outs("rt_unused", O_DEF, 2'd0);

        // Same operands with rt in use: stall, then mem_busy x3 inside LOAD_STALL
        @(negedge clk);
        pc_low = 0;
        id_uses_rt = 1'b1;
        #1 check_outs("rt_lu", O_STALL, 2'd0);
        @(negedge clk);
        ex_memread = 1'b0; mem_busy = 1'b1;
        #1 check_outs("mb_c0", O_BUSY, 2'd1);
        @(negedge clk);
        #1 check_outs("mb_c1", O_BUSY, 2'd2);
        @(negedge clk);
        #1 check_outs("mb_c2", O_BUSY, 2'd2);
        @(negedge clk);
        mem_busy = 1'b0;
        #1 check_outs("mb_resume", O_STALL, 2'd2);
        @(negedge clk);
        #1 check_outs("mb_run", O_DEF, 2'd0);
        check("mb_pc_low_total", 32'(pc_low), 32'd5);

        // mem_busy held 15 cycles: error rises on the 15th edge and is sticky
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            mem_busy = 1'b1;
            #1 check($sformatf("to_pre_err_%0d", i), 32'(mem_timeout_err), 32'd0);
        end
        @(negedge clk);
        mem_busy = 1'b0;
        #1 check("to_err_set", 32'(mem_timeout_err), 32'd1);
        check_outs("to_release", O_DEF, 2'd2);
        repeat (3) @(negedge clk);
        #1 check("to_err_sticky", 32'(mem_timeout_err), 32'd1);
        check("to_state_run", 32'(seq_state), 32'd0);

        // Async reset while in LOAD_STALL
        @(negedge clk);
        ex_memread = 1'b1; ex_rt = 3'd4; id_rs = 3'd4;
        #1 check_outs("rs_lu", O_STALL, 2'd0);
        @(negedge clk);
        ex_memread = 1'b0;
        #1 check_outs("rs_stall", O_STALL, 2'd1);
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_pre", 32'(stall_cycles), 32'd23);
        check("perf_flush_pre", 32'(flush_count), 32'd1);
`endif
        #1 rst = 1'b1;
        #1 check_outs("rs_async", O_DEF, 2'd0);
        check("rs_err_clr", 32'(mem_timeout_err), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_rst", 32'(stall_cycles), 32'd0);
        check("perf_flush_rst", 32'(flush_count), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1 check_outs("rs_after", O_DEF, 2'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
